// File: rtl/rf_dump_tx.sv
// rf_dump_tx: walks x0..x31 through the register file's debug read port and
// sends each register as a 5-byte 8N1 UART frame: {index}, w[31:24], w[23:16],
// w[15:8], w[7:0]. The serial line idles high and stays high during LOAD cycles.
module rf_dump_tx #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [4:0]  dbg_addr,
  input  logic [31:0] dbg_data,
  output logic        uart_tx,
  output logic        busy,
  output logic        done
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  state_t        r_state, w_next;
  logic [BW-1:0] r_baud;
  logic [3:0]    r_bit;
  logic [2:0]    r_byte;
  logic [4:0]    r_addr;
  logic [31:0]   r_word;
  logic          r_done;

  logic          w_bit_end, w_reg_end;
  logic [7:0]    w_byte;
  logic          w_tx_bit;

  assign w_bit_end = (r_baud == BW'(CLKS_PER_BIT - 1));
  assign w_reg_end = w_bit_end && (r_bit == 4'd9) && (r_byte == 3'd4);

  // State register; reset drops any dump in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state: one LOAD cycle per register, then 50 bit periods of SEND
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = LOAD;
      LOAD:    w_next = SEND;
      SEND:    if (w_reg_end) w_next = (r_addr == 5'd31) ? IDLE : LOAD;
      default: w_next = IDLE;
    endcase
  end

  // Word capture, baud/bit/byte counters, register index and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_baud <= '0;
      r_bit  <= 4'd0;
      r_byte <= 3'd0;
      r_addr <= 5'd0;
      r_word <= 32'd0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_addr <= 5'd0;
          r_baud <= '0;
          r_bit  <= 4'd0;
          r_byte <= 3'd0;
        end
        LOAD: begin
          // dbg_data is only looked at here, so later RF writes cannot
          // corrupt the frame being sent
          r_word <= dbg_data;
          r_baud <= '0;
          r_bit  <= 4'd0;
          r_byte <= 3'd0;
        end
        SEND: begin
          if (!w_bit_end) begin
            r_baud <= r_baud + BW'(1);
          end else begin
            r_baud <= '0;
            if (r_bit != 4'd9) begin
              r_bit <= r_bit + 4'd1;
            end else begin
              r_bit <= 4'd0;
              if (r_byte != 3'd4) begin
                r_byte <= r_byte + 3'd1;
              end else begin
                r_byte <= 3'd0;
                // index parks at 31 after the last register
                if (r_addr != 5'd31) r_addr <= r_addr + 5'd1;
                else                 r_done <= 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Byte currently on the wire
  always_comb begin
    w_byte = r_word[7:0];
    case (r_byte)
      3'd0:    w_byte = {3'b000, r_addr};
      3'd1:    w_byte = r_word[31:24];
      3'd2:    w_byte = r_word[23:16];
      3'd3:    w_byte = r_word[15:8];
      default: w_byte = r_word[7:0];
    endcase
  end

  // Bit 0 is the start bit, bits 1..8 data LSB first, bit 9 the stop bit
  always_comb begin
    w_tx_bit = 1'b1;
    if (r_bit == 4'd0)      w_tx_bit = 1'b0;
    else if (r_bit != 4'd9) w_tx_bit = w_byte[r_bit[2:0] - 3'd1];
  end

  // Line is driven from state so an async reset forces it high mid-byte
  assign uart_tx  = (r_state == SEND) ? w_tx_bit : 1'b1;
  assign busy     = (r_state != IDLE);
  assign done     = r_done;
  assign dbg_addr = r_addr;

endmodule

// File: tb/tb_rf_dump_tx.sv
// tb_rf_dump_tx: directed bench for rf_dump_tx with CLKS_PER_BIT=4 and an RF
// model where reg k = 32'h1000_0000+k (x0 = 0). A negedge monitor decodes the
// serial line into bytes, logs the line level per cycle and records done pulses.
module tb_rf_dump_tx;
  localparam int CPB = 4;
  localparam int DUMP = 32 * (1 + 50 * CPB);   // 6432

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic        uart_tx, busy, done;

  logic [31:0] rf [32];
  assign dbg_data = rf[dbg_addr];

  rf_dump_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data), .uart_tx(uart_tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor state
  logic [7:0] rx_q [$];
  int         done_q [$];
  logic       txlog [65536];
  logic       rx_act = 1'b0;
  int         rx_k = 0;
  logic [7:0] rx_sh = 8'h00;
  int         frame_err = 0;

  // UART decoder: k=0 is the first cycle of the start bit, bits sampled mid-period
  always @(negedge clk) begin
    if (cyc < 65536) txlog[cyc] <= uart_tx;
    if (done) done_q.push_back(cyc);
    if (!rst_n) begin
      rx_act <= 1'b0;
    end else if (!rx_act) begin
      if (uart_tx == 1'b0) begin
        rx_act <= 1'b1;
        rx_k   <= 1;
      end
    end else begin
      if (rx_k == 2 && uart_tx !== 1'b0) frame_err <= frame_err + 1;
      if (rx_k >= 6 && rx_k <= 34 && ((rx_k - 2) % 4) == 0)
        rx_sh[(rx_k - 6) / 4] <= uart_tx;
      if (rx_k == 38) begin
        if (uart_tx !== 1'b1) frame_err <= frame_err + 1;
        rx_q.push_back(rx_sh);
      end
      rx_act <= (rx_k != 39);
      rx_k   <= rx_k + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  function automatic logic [7:0] exp_byte(input int r, input int j);
    logic [31:0] w;
    w = (r == 0) ? 32'h0 : 32'h1000_0000 + r;
    case (j)
      0:       return 8'(r);
      1:       return w[31:24];
      2:       return w[23:16];
      3:       return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

  function automatic logic [7:0] rxb(input int i);
    if (i < rx_q.size()) return rx_q[i];
    return 8'hEE;
  endfunction

  function automatic logic [39:0] frame(input int base, input int r);
    return {rxb(base+5*r), rxb(base+5*r+1), rxb(base+5*r+2), rxb(base+5*r+3), rxb(base+5*r+4)};
  endfunction

  function automatic int dump_bad(input int base);
    int bad = 0;
    for (int i = 0; i < 160; i++)
      if (rxb(base + i) !== exp_byte(i / 5, i % 5)) bad++;
    return bad;
  endfunction

  function automatic int high_run(input int from, input int to);
    int h = 0;
    for (int i = from; i <= to; i++) if (txlog[i] === 1'b1) h++;
    return h;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    while (!done && cyc < limit) tick(1);
    chk(tag, done, 1'b1);
  endtask

  int s, d1, d2;

  initial begin
    for (int k = 0; k < 32; k++) rf[k] = (k == 0) ? 32'h0 : 32'h1000_0000 + k;

    // reset state
    tick(3);
    chk("rst_tx", uart_tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_addr", dbg_addr, 5'd0);
    rst_n = 1'b1;
    tick(3);
    chk("idle_busy", busy, 1'b0);

    // basic dump, extra starts while busy, x3 changed mid-frame
    pulse_start();
    s = cyc;
    chk("load_busy", busy, 1'b1);
    chk("load_addr", dbg_addr, 5'd0);
    chk("load_tx_high", uart_tx, 1'b1);
    tick(1);
    chk("first_start_bit", uart_tx, 1'b0);
    wait_cyc(s + 700);
    chk("x3_in_flight", dbg_addr, 5'd3);
    rf[3] = 32'hDEAD_BEEF;
    wait_cyc(s + 1000);
    pulse_start();
    wait_cyc(s + 6000);
    pulse_start();
    wait_done("done_seen", s + DUMP + 100);
    chk("done_latency", cyc - s, DUMP);
    chk("done_busy_low", busy, 1'b0);
    chk("done_addr_31", dbg_addr, 5'd31);
    tick(1);
    chk("done_one_cycle", done, 1'b0);
    rf[3] = 32'h1000_0003;
    tick(60);
    chk("byte_count", rx_q.size(), 160);
    chk("done_count", done_q.size(), 1);
    chk("frame_r5", frame(0, 5), 40'h05_10_00_00_05);
    chk("frame_r0", frame(0, 0), 40'h00_00_00_00_00);
    chk("frame_r3_isolated", frame(0, 3), 40'h03_10_00_00_03);
    chk("dump1_bytes_bad", dump_bad(0), 0);
    chk("frame_errors", frame_err, 0);
    // bit timing of the first byte (0x00) and the x0 -> x1 gap
    chk("start_bit_4low", high_run(s + 1, s + 4), 0);
    chk("data_00_low", high_run(s + 5, s + 36), 0);
    chk("stop_bit_4high", high_run(s + 37, s + 40), 4);
    chk("next_start_low", txlog[s + 41], 1'b0);
    chk("gap_pre_low", txlog[s + 196], 1'b0);
    chk("gap_5_high", high_run(s + 197, s + 201), 5);
    chk("gap_post_low", txlog[s + 202], 1'b0);

    // reset during byte 2 of register 7
    rx_q.delete();
    done_q.delete();
    frame_err = 0;
    pulse_start();
    s = cyc;
    wait_cyc(s + 1460);
    chk("pre_reset_tx_low", uart_tx, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", uart_tx, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_addr", dbg_addr, 5'd0);
    tick(3);
    rst_n = 1'b1;
    tick(200);
    chk("no_done_after_rst", done_q.size(), 0);
    chk("aborted_bytes", rx_q.size(), 36);
    chk("idle_after_rst", busy, 1'b0);

    // restart after reset gives a complete dump
    rx_q.delete();
    frame_err = 0;
    pulse_start();
    s = cyc;
    wait_done("redump_done", s + DUMP + 100);
    tick(60);
    chk("redump_bytes", rx_q.size(), 160);
    chk("redump_bad", dump_bad(0), 0);
    chk("redump_done_count", done_q.size(), 1);
    chk("redump_frame_err", frame_err, 0);

    // start held high: back-to-back dumps with one idle cycle between
    rx_q.delete();
    done_q.delete();
    frame_err = 0;
    start = 1'b1;
    tick(1);
    s = cyc;
    wait_cyc(s + 14000);
    start = 1'b0;
    chk("held_done_count", done_q.size(), 2);
    d1 = (done_q.size() > 0) ? done_q[0] : 0;
    d2 = (done_q.size() > 1) ? done_q[1] : 0;
    chk("held_d1", d1 - s, DUMP);
    chk("held_d2", d2 - d1, DUMP + 1);
    chk("held_pre_low", txlog[d1 - 5], 1'b0);
    chk("held_idle_gap", high_run(d1 - 4, d1 + 1), 6);
    chk("held_next_start", txlog[d1 + 2], 1'b0);
    chk("held_dump1_bad", dump_bad(0), 0);
    chk("held_dump2_bad", dump_bad(160), 0);
    chk("held_frame_err", frame_err, 0);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rf_dump_tx.md
# rf_dump_tx

- Debug reader for the register file's asynchronous read side, used on the board build of the single-cycle CPU.
- On a start pulse it walks registers x0..x31 through a dedicated debug read port and captures each 32-bit value.
- It serializes each register as a 5-byte 8N1 UART frame on one TX pin, so a host terminal can dump the whole architectural state without halting the core.

## Interface

Parameters:
- CLKS_PER_BIT, 217, clock cycles per UART bit (25 MHz / 115200); legal range ≥ 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  dump request, sampled each rising edge; honoured only when busy=0.
- dbg_addr  output  5  register index driven to the register file's debug read port.
- dbg_data  input  32  combinational read data for dbg_addr (valid the same cycle).
- uart_tx  output  1  serial line, idle high.
- busy  output  1  high from the accepted start until the dump completes.
- done  output  1  one-cycle pulse when the last stop bit of x31 completes.

## Operation

- FSM states: IDLE, LOAD, SEND.
- IDLE → LOAD on start=1. Set dbg_addr=0 and busy=1.
- LOAD lasts exactly one cycle:
  - Capture dbg_data into a 32-bit word register.
  - Build the byte sequence {3'b000, dbg_addr}, word[31:24], word[23:16], word[15:8], word[7:0].
  - Go to SEND.
- SEND transmits the 5 bytes back-to-back with no idle gap. Each byte is:
  - start bit (0),
  - 8 data bits, LSB first,
  - stop bit (1).
- Each bit is held exactly CLKS_PER_BIT cycles.
- After the stop bit of byte 5:
  - If dbg_addr<31: increment dbg_addr and go to LOAD.
  - If dbg_addr==31: pulse done, clear busy, go to IDLE. dbg_addr stays at 31.
- x0 is dumped like any other index; its value is whatever dbg_data returns (0 in a correct RF).
- start while busy=1 is ignored; no queuing.
- Internal counters:
  - baud counter, 0..CLKS_PER_BIT-1
  - bit index, 0..9
  - byte index, 0..4
  - all wrap and reset to 0 at each new bit, byte, or register.
- dbg_data is sampled only in LOAD. Changes during SEND do not affect the frame in flight.

## Timing

- Reset values: uart_tx=1, busy=0, done=0, dbg_addr=0, FSM=IDLE, all counters 0.
- Reset asserted mid-dump:
  - All outputs take their reset values immediately (asynchronous), including uart_tx forced high mid-byte.
  - After release, the block waits in IDLE for a new start.
- Edge E0 samples start=1 in IDLE:
  - after E0: busy=1, dbg_addr=0, state LOAD.
  - after E1: uart_tx=0 (start bit of byte 1).
- Per register: 1 LOAD cycle + 50·CLKS_PER_BIT SEND cycles. uart_tx stays high during LOAD cycles.
- done rises on edge E0 + 32·(1+50·CLKS_PER_BIT) and falls the next edge. busy falls on that same edge.
- start=1 on the edge where done is asserted is ignored, because the FSM was not in IDLE. start=1 on the following edge begins a new dump.
- Holding start high continuously therefore yields back-to-back dumps separated by one IDLE cycle.

## Test plan

All cases use CLKS_PER_BIT=4 and a behavioural RF model where reg k = 32'h1000_0000+k, with x0=0.

- Basic dump: pulse start once.
  - Decode 160 bytes from uart_tx.
  - Register 5 frame must be 05 10 00 00 05.
  - Register 0 frame must be 00 00 00 00 00.
  - done must fire exactly 6432 cycles after the start edge.
- Bit timing: on the first byte, measure uart_tx.
  - Start bit low for exactly 4 cycles.
  - Data bits for 0x00.
  - Stop bit high for 4 cycles.
  - The next start bit follows immediately.
  - The gap between the register-0 and register-1 frames is exactly 5 high cycles (stop + LOAD).
- Start ignored while busy: pulse start again at cycle 1000 and cycle 6000.
  - Exactly one done.
  - Exactly 160 bytes.
- Capture isolation: change the RF model's x3 to 32'hDEAD_BEEF while register 3's frame is being sent.
  - Frame 3 still carries 10 00 00 03.
- Reset mid-operation: assert rst_n=0 during byte 2 of register 7.
  - uart_tx=1, busy=0, dbg_addr=0 within the same cycle.
  - No done pulse.
  - A later start produces a complete, correct 160-byte dump.
- Held start: keep start=1 for 14000 cycles.
  - Two complete dumps.
  - Exactly one idle-high cycle between the x31 stop bit and the next LOAD cycle.
